index_merge_fsm: RTL and testbench

Parametrised N-channel successor to the output merge FSM of the serializer datapath. It drains `NUM_CH` show-ahead source FIFOs, each holding encoded bytes tagged with their absolute output byte index. It writes them to the output FIFO in strictly increasing index order, one byte per cycle. Unlike the two-channel merger it replaces, it detects index gaps, duplicate indices and frame overflow, flushes the partial frame on error, and reports frame length and status.

---
 rtl/index_merge_pkg.sv | 16 +
 rtl/index_match.sv | 38 +++
 rtl/index_merge_fsm.sv | 134 +++++++++++++
 tb/tb_index_merge_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/index_merge_pkg.sv
// Shared types and constants for the index-ordered N-channel output merger.
package index_merge_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MERGE,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_GAP  = 2'd1;
   localparam logic [1:0] ERR_DUP  = 2'd2;
   localparam logic [1:0] ERR_OVF  = 2'd3;

endpackage

// File: rtl/index_match.sv
// Combinational head matcher: which channel heads carry the expected output index,
// whether more than one does, and the byte of the matching head.
module index_match #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 10
) (
   input  logic [NUM_CH*DATA_W-1:0] ch_q,
   input  logic [NUM_CH*IDX_W-1:0]  ch_index_q,
   input  logic [NUM_CH-1:0]        ch_empty,
   input  logic [IDX_W:0]           out_index,
   output logic [NUM_CH-1:0]        hit,
   output logic                     multi_hit,
   output logic                     any_nonempty,
   output logic [DATA_W-1:0]        hit_data
);

   logic found;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      hit       = '0;
      hit_data  = '0;
      multi_hit = 1'b0;
      found     = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!ch_empty[c] && {1'b0, ch_index_q[c*IDX_W +: IDX_W]} == out_index) begin
            hit[c]   = 1'b1;
            hit_data = ch_q[c*DATA_W +: DATA_W];
            if (found) multi_hit = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any_nonempty = ~&ch_empty;

endmodule

// File: rtl/index_merge_fsm.sv
// Merges NUM_CH index-tagged byte streams into the output FIFO in index order,
// flushing the partial frame on gap, duplicate or overflow.
module index_merge_fsm
   import index_merge_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_q,
   input  logic [NUM_CH*IDX_W-1:0]  ch_index_q,
   input  logic [NUM_CH-1:0]        ch_empty,
   output logic [NUM_CH-1:0]        ch_pop,
   input  logic [NUM_CH-1:0]        ch_data_valid,
   output logic [NUM_CH-1:0]        ch_data_accepted,
   input  logic                     out_fifo_full,
   output logic                     out_fifo_push,
   output logic [DATA_W-1:0]        out_fifo_data,
   output logic                     out_fifo_clr,
   output logic                     frame_done,
   output logic [IDX_W:0]           frame_len,
   output logic [1:0]               err_code
);

   localparam logic [IDX_W:0] LAST_IDX = {1'b0, {IDX_W{1'b1}}};

   state_t              state;
   logic [IDX_W:0]      out_index;
   logic [NUM_CH-1:0]   hit;
   logic                multi_hit;
   logic                any_nonempty;
   logic [DATA_W-1:0]   hit_data;
   logic                single_hit;
   logic                others_nonempty;

   index_match #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_match (
      .ch_q         (ch_q),
      .ch_index_q   (ch_index_q),
      .ch_empty     (ch_empty),
      .out_index    (out_index),
      .hit          (hit),
      .multi_hit    (multi_hit),
      .any_nonempty (any_nonempty),
      .hit_data     (hit_data)
   );

   assign single_hit      = (|hit) && !multi_hit;
   // Overflow is only visible through channels other than the one being popped.
   assign others_nonempty = |(~ch_empty & ~hit);

   always_comb begin
      ch_pop        = '0;
      out_fifo_push = 1'b0;
      out_fifo_data = '0;
      case (state)
         S_MERGE: begin
            if (single_hit && !out_fifo_full) begin
               out_fifo_push = 1'b1;
               out_fifo_data = hit_data;
               ch_pop        = hit;
            end
         end
         S_FLUSH: ch_pop = ~ch_empty;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         out_index        <= '0;
         frame_len        <= '0;
         err_code         <= ERR_NONE;
         out_fifo_clr     <= 1'b0;
         frame_done       <= 1'b0;
         ch_data_accepted <= '0;
      end else begin
         out_fifo_clr     <= 1'b0;
         frame_done       <= 1'b0;
         ch_data_accepted <= '0;
         case (state)
            S_IDLE: begin
               if (&ch_data_valid) begin
                  out_index <= '0;
                  frame_len <= '0;
                  err_code  <= ERR_NONE;
                  state     <= S_MERGE;
               end
            end
            S_MERGE: begin
               if (!any_nonempty) begin
                  frame_len        <= out_index;
                  frame_done       <= 1'b1;
                  ch_data_accepted <= '1;
                  state            <= S_DONE;
               end else if (multi_hit) begin
                  err_code     <= ERR_DUP;
                  out_fifo_clr <= 1'b1;
                  state        <= S_FLUSH;
               end else if (!single_hit) begin
                  err_code     <= ERR_GAP;
                  out_fifo_clr <= 1'b1;
                  state        <= S_FLUSH;
               end else if (!out_fifo_full) begin
                  out_index <= out_index + 1'b1;
                  if (out_index == LAST_IDX && others_nonempty) begin
                     err_code     <= ERR_OVF;
                     out_fifo_clr <= 1'b1;
                     state        <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (!any_nonempty) begin
                  frame_len        <= '0;
                  frame_done       <= 1'b1;
                  ch_data_accepted <= '1;
                  state            <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_index_merge_fsm.sv
// Directed bench for index_merge_fsm (3 channels, 3-bit index) with FIFO models.
module tb_index_merge_fsm;
   import index_merge_pkg::*;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_CH*DATA_W-1:0] ch_q;
   logic [NUM_CH*IDX_W-1:0]  ch_index_q;
   logic [NUM_CH-1:0]        ch_empty;
   logic [NUM_CH-1:0]        ch_pop;
   logic [NUM_CH-1:0]        ch_data_valid;
   logic [NUM_CH-1:0]        ch_data_accepted;
   logic                     out_fifo_full;
   logic                     out_fifo_push;
   logic [DATA_W-1:0]        out_fifo_data;
   logic                     out_fifo_clr;
   logic                     frame_done;
   logic [IDX_W:0]           frame_len;
   logic [1:0]               err_code;

   index_merge_fsm #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ch_q             (ch_q),
      .ch_index_q       (ch_index_q),
      .ch_empty         (ch_empty),
      .ch_pop           (ch_pop),
      .ch_data_valid    (ch_data_valid),
      .ch_data_accepted (ch_data_accepted),
      .out_fifo_full    (out_fifo_full),
      .out_fifo_push    (out_fifo_push),
      .out_fifo_data    (out_fifo_data),
      .out_fifo_clr     (out_fifo_clr),
      .frame_done       (frame_done),
      .frame_len        (frame_len),
      .err_code         (err_code)
   );

   always #5 clk = ~clk;

   ent_t              chq [NUM_CH][$];
   logic [DATA_W-1:0] outq[$];
   int                total = 0;
   int                passed = 0;
   int                cyc, full_s, full_l;
   int                push_cnt, clr_cnt, acc_cnt, viol_cnt, clr_cyc, done_cyc;
   logic              seen;
   logic [IDX_W:0]    got_len;
   logic [1:0]        got_err;
   logic [NUM_CH-1:0] acc_val;

   function automatic logic [DATA_W-1:0] byte_of(input int c, input int idx);
      return DATA_W'((c << 4) | idx);
   endfunction

   task automatic load(input int c, input int idx);
      ent_t e;
      e.idx  = IDX_W'(idx);
      e.data = byte_of(c, idx);
      chq[c].push_back(e);
   endtask

   task automatic update_heads();
      for (int c = 0; c < NUM_CH; c++) begin
         ch_empty[c] = (chq[c].size() == 0);
         ch_q[c*DATA_W +: DATA_W]      = ch_empty[c] ? '0 : chq[c][0].data;
         ch_index_q[c*IDX_W +: IDX_W]  = ch_empty[c] ? '0 : chq[c][0].idx;
      end
   endtask

   task automatic reset_stats();
      outq.delete();
      cyc = 0; push_cnt = 0; clr_cnt = 0; acc_cnt = 0; viol_cnt = 0;
      clr_cyc = 0; done_cyc = 0; seen = 1'b0; acc_val = '0;
      got_len = '0; got_err = '0;
   endtask

   // One clock: sample outputs at negedge, apply pops after the rising edge.
   task automatic cycle();
      logic [NUM_CH-1:0] pops;
      logic              drop_valid;
      cyc++;
      out_fifo_full = (cyc >= full_s) && (cyc < full_s + full_l);
      @(negedge clk);
      pops       = ch_pop;
      drop_valid = 1'b0;
      if (out_fifo_full && (out_fifo_push || |ch_pop)) viol_cnt++;
      if (out_fifo_push) begin
         outq.push_back(out_fifo_data);
         push_cnt++;
      end
      if (out_fifo_clr) begin
         outq.delete();
         clr_cnt++;
         clr_cyc = cyc;
      end
      if (|ch_data_accepted) begin
         acc_cnt++;
         acc_val    = ch_data_accepted;
         drop_valid = 1'b1;
      end
      if (frame_done) begin
         seen     = 1'b1;
         got_len  = frame_len;
         got_err  = err_code;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pops[c]) begin
            if (chq[c].size() == 0) viol_cnt++;
            else void'(chq[c].pop_front());
         end
      end
      update_heads();
      if (drop_valid) ch_data_valid = '0;
      out_fifo_full = 1'b0;
   endtask

   task automatic run_frame(input int fs, input int fl);
      reset_stats();
      full_s = fs;
      full_l = fl;
      update_heads();
      ch_data_valid = '1;
      for (int i = 0; i < 200 && !seen; i++) cycle();
      full_s = 0;
      full_l = 0;
      total++;
      if (!seen) begin
         $display("FAIL frame_timeout: frame_done not seen, cycles=%0d", cyc);
         ch_data_valid = '0;
      end else passed++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ch_data_valid = '0; out_fifo_full = 1'b0;
      full_s = 0; full_l = 0;
      update_heads();
      #12;
      total++;
      if ({ch_pop, out_fifo_push, out_fifo_data, out_fifo_clr, frame_done, frame_len,
           err_code, ch_data_accepted} !== '0)
         $display("FAIL reset_outputs: some output nonzero during reset");
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_in_order();
      int exp_ch[5] = '{0, 1, 0, 1, 0};
      load(0, 0); load(0, 2); load(0, 4); load(1, 1); load(1, 3);
      run_frame(0, 0);
      total++;
      if (push_cnt !== 5) $display("FAIL order_pushes: got %0d want 5", push_cnt); else passed++;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (outq.size() <= i || outq[i] !== byte_of(exp_ch[i], i))
            $display("FAIL order_byte%0d: got %0h want %0h", i,
                     (outq.size() > i) ? outq[i] : 8'hxx, byte_of(exp_ch[i], i));
         else passed++;
      end
      total++;
      if (got_len !== 4'd5) $display("FAIL order_len: got %0d want 5", got_len); else passed++;
      total++;
      if (got_err !== ERR_NONE) $display("FAIL order_err: got %0d want 0", got_err); else passed++;
      total++;
      if (acc_cnt !== 1 || acc_val !== 3'b111)
         $display("FAIL order_accept: count %0d value %b want 1 / 111", acc_cnt, acc_val);
      else passed++;
      total++;
      if (done_cyc !== 8) $display("FAIL order_latency: got %0d want 8", done_cyc); else passed++;
      total++;
      if (frame_len !== 4'd5) $display("FAIL order_len_held: got %0d want 5", frame_len); else passed++;
   endtask

   task automatic test_stall();
      load(0, 0); load(0, 2); load(0, 4); load(1, 1); load(1, 3);
      run_frame(3, 3);
      total++;
      if (viol_cnt !== 0) $display("FAIL stall_activity: %0d push/pop while full, want 0", viol_cnt);
      else passed++;
      total++;
      if (outq.size() !== 5 || outq[1] !== byte_of(1, 1) || outq[4] !== byte_of(0, 4))
         $display("FAIL stall_order: size %0d want 5 with bytes 11 and 04 at 1 and 4", outq.size());
      else passed++;
      total++;
      if (got_len !== 4'd5) $display("FAIL stall_len: got %0d want 5", got_len); else passed++;
      total++;
      if (done_cyc !== 11) $display("FAIL stall_latency: got %0d want 11", done_cyc); else passed++;
   endtask

   task automatic test_gap();
      load(0, 0); load(0, 1); load(1, 3);
      run_frame(0, 0);
      total++;
      if (push_cnt !== 2) $display("FAIL gap_pushes: got %0d want 2", push_cnt); else passed++;
      total++;
      if (got_err !== ERR_GAP) $display("FAIL gap_err: got %0d want 1", got_err); else passed++;
      total++;
      if (clr_cnt !== 1 || clr_cyc !== 5) $display("FAIL gap_clr: count %0d at %0d want 1 at 5", clr_cnt, clr_cyc);
      else passed++;
      total++;
      if (chq[1].size() !== 0 || outq.size() !== 0)
         $display("FAIL gap_flush: ch1 left %0d, out left %0d want 0/0", chq[1].size(), outq.size());
      else passed++;
      total++;
      if (got_len !== 4'd0) $display("FAIL gap_len: got %0d want 0", got_len); else passed++;
   endtask

   task automatic test_duplicate();
      load(0, 0); load(0, 5); load(1, 0);
      run_frame(0, 0);
      total++;
      if (push_cnt !== 0) $display("FAIL dup_pushes: got %0d want 0", push_cnt); else passed++;
      total++;
      if (got_err !== ERR_DUP) $display("FAIL dup_err: got %0d want 2", got_err); else passed++;
      total++;
      if (clr_cnt !== 1 || clr_cyc !== 3) $display("FAIL dup_clr: count %0d at %0d want 1 at 3", clr_cnt, clr_cyc);
      else passed++;
      total++;
      if (chq[0].size() !== 0 || chq[1].size() !== 0 || got_len !== 4'd0)
         $display("FAIL dup_flush: ch0 %0d ch1 %0d len %0d want 0/0/0", chq[0].size(), chq[1].size(), got_len);
      else passed++;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i += 2) load(0, i);
      load(0, 0);
      for (int i = 1; i < 8; i += 2) load(1, i);
      run_frame(0, 0);
      total++;
      if (push_cnt !== 8) $display("FAIL ovf_pushes: got %0d want 8", push_cnt); else passed++;
      total++;
      if (got_err !== ERR_OVF) $display("FAIL ovf_err: got %0d want 3", got_err); else passed++;
      total++;
      if (clr_cnt !== 1 || got_len !== 4'd0 || chq[0].size() !== 0)
         $display("FAIL ovf_flush: clr %0d len %0d ch0 %0d want 1/0/0", clr_cnt, got_len, chq[0].size());
      else passed++;
   endtask

   task automatic test_full_frame();
      for (int i = 0; i < 8; i += 2) load(0, i);
      for (int i = 1; i < 8; i += 2) load(1, i);
      run_frame(0, 0);
      total++;
      if (got_len !== 4'd8) $display("FAIL full_len: got %0d want 8", got_len); else passed++;
      total++;
      if (got_err !== ERR_NONE || clr_cnt !== 0)
         $display("FAIL full_err: err %0d clr %0d want 0/0", got_err, clr_cnt);
      else passed++;
      total++;
      if (outq.size() !== 8 || outq[7] !== byte_of(1, 7))
         $display("FAIL full_data: size %0d want 8 ending in 17", outq.size());
      else passed++;
   endtask

   task automatic test_reset_mid_frame();
      reset_stats();
      for (int i = 0; i < 6; i++) load(i % 3, i);
      update_heads();
      ch_data_valid = '1;
      for (int i = 0; i < 3; i++) cycle();
      total++;
      if (push_cnt !== 2) $display("FAIL midrst_pre_pushes: got %0d want 2", push_cnt); else passed++;
      reset_n = 1'b0;
      ch_data_valid = '0;
      #1;
      total++;
      if ({ch_pop, out_fifo_push, out_fifo_data, out_fifo_clr, frame_done, frame_len,
           err_code, ch_data_accepted} !== '0)
         $display("FAIL midrst_outputs: some output nonzero during reset");
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < NUM_CH; c++) chq[c].delete();
      for (int i = 0; i < 6; i++) load(i % 3, i);
      update_heads();
      @(posedge clk);
      #1;
      reset_stats();
      for (int i = 0; i < 3; i++) cycle();
      total++;
      if (push_cnt !== 0 || clr_cnt !== 0) $display("FAIL midrst_idle: pushes %0d clr %0d want 0/0", push_cnt, clr_cnt);
      else passed++;
      run_frame(0, 0);
      total++;
      if (outq.size() !== 6 || outq[0] !== byte_of(0, 0) || outq[5] !== byte_of(2, 5))
         $display("FAIL midrst_data: size %0d want 6 from 00 to 25", outq.size());
      else passed++;
      total++;
      if (got_len !== 4'd6 || got_err !== ERR_NONE)
         $display("FAIL midrst_len: len %0d err %0d want 6/0", got_len, got_err);
      else passed++;
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) chq[c].delete();
      test_reset();
      test_in_order();
      test_stall();
      test_gap();
      test_duplicate();
      test_overflow();
      test_full_frame();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
